// File: rtl/vend_pkg.sv
// Shared definitions for the vending machine change path.
// Holds the coin values, the default item price and the change sequencer's
// state encoding. The encoding is fixed so that the numeric state seen on the
// debug port stays stable between builds.
package vend_pkg;

    localparam int PRICE_DEFAULT = 30;
    localparam int DIME_CENTS    = 10;
    localparam int NICKEL_CENTS  = 5;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CALC    = 3'd1,
        S_EJ_DIME = 3'd2,
        S_WT_DIME = 3'd3,
        S_EJ_NICK = 3'd4,
        S_WT_NICK = 3'd5,
        S_DONE    = 3'd6,
        S_JAM     = 3'd7
    } chg_state_t;

endpackage

// File: rtl/coin_hopper_if.sv
// One coin hopper channel: eject pulse, ack wait timer and inventory counter.
// Ports:
//   clk, reset      clock / asynchronous active-high reset
//   eject_en        sequencer is in the eject state for this coin
//   wait_en         sequencer is waiting for this coin's ack
//   ack             hopper sensor: one coin left the chute
//   restock_en      load the inventory from restock_val
//   restock_hold    blocks restock while any coin ack is outstanding
//   restock_val     new inventory value
//   eject           1-cycle release pulse to the hopper
//   ack_seen        ack accepted while waiting
//   timed_out       last waiting cycle passed without an ack
//   inv             current inventory
// Handshake: eject is high for one cycle; the coin is then owed until ack is
// seen during wait_en. Acks outside wait_en are ignored and never touch inv.
module coin_hopper_if #(
    parameter int INV_W   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             eject_en,
    input  logic             wait_en,
    input  logic             ack,
    input  logic             restock_en,
    input  logic             restock_hold,
    input  logic [INV_W-1:0] restock_val,
    output logic             eject,
    output logic             ack_seen,
    output logic             timed_out,
    output logic [INV_W-1:0] inv
);

    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0]    timer_q, timer_d;
    logic [INV_W-1:0] inv_q, inv_d;

    assign eject     = eject_en;
    assign ack_seen  = wait_en & ack;
    // TIMEOUT waiting cycles in a row without an ack declare a jam.
    assign timed_out = wait_en & ~ack & (timer_q == TW'(TIMEOUT - 1));
    assign inv       = inv_q;

    always_comb begin
        timer_d = timer_q;
        if (eject_en) begin
            timer_d = '0;
        end else if (wait_en && !ack && !timed_out) begin
            timer_d = timer_q + 1'b1;
        end
    end

    // An ack wins over a same-cycle restock; restock_hold covers that case too
    // since acks are only accepted while waiting.
    always_comb begin
        inv_d = inv_q;
        if (ack_seen) begin
            if (inv_q != '0) begin
                inv_d = inv_q - 1'b1;
            end
        end else if (restock_en && !restock_hold) begin
            inv_d = restock_val;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer_q <= '0;
            inv_q   <= '0;
        end else begin
            timer_q <= timer_d;
            inv_q   <= inv_d;
        end
    end

endmodule

// File: rtl/change_dispense_ctrl.sv
// Change path sequencer for the vending machine.
// On vend/refund it snapshots credit, computes change owed, splits it into
// dimes first then nickels, and pays out one coin at a time through two
// coin_hopper_if channels. Vends that cannot be paid out exactly are refused.
// Ports:
//   clk, reset                 clock / asynchronous active-high reset
//   vend_req, refund_req       1-cycle customer requests (only taken in IDLE)
//   credit                     inserted credit in cents
//   dime_ack, nickel_ack       hopper sensors
//   restock_en/_dimes/_nick    inventory load
//   dime_eject, nickel_eject   1-cycle coin release pulses
//   vend_ok, vend_denied       vend outcome pulses
//   credit_clear               acceptor zeroes its credit
//   busy, done, jam            status (jam is sticky until reset)
//   exact_only                 too few coins to guarantee change
//   state_dbg                  current sequencer state (vend_pkg::chg_state_t)
module change_dispense_ctrl
    import vend_pkg::*;
#(
    parameter int PRICE   = PRICE_DEFAULT,
    parameter int N       = 6,
    parameter int INV_W   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             vend_req,
    input  logic             refund_req,
    input  logic [N-1:0]     credit,
    input  logic             dime_ack,
    input  logic             nickel_ack,
    input  logic             restock_en,
    input  logic [INV_W-1:0] restock_dimes,
    input  logic [INV_W-1:0] restock_nick,
    output logic             dime_eject,
    output logic             nickel_eject,
    output logic             vend_ok,
    output logic             vend_denied,
    output logic             credit_clear,
    output logic             busy,
    output logic             done,
    output logic             jam,
    output logic             exact_only,
    output logic [2:0]       state_dbg
);

    localparam int DW = N - 3;                   // dime count: change/10 fits
    localparam int NW = N - 2;                   // nickel count: change/5 when no dimes
    localparam int AW = (N > INV_W) ? N : INV_W; // common width for change arithmetic

    chg_state_t    state_q, state_d;
    logic [N-1:0]  change_q, change_d;
    logic          is_vend_q, is_vend_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic [NW-1:0] ncnt_q, ncnt_d;

    logic [INV_W-1:0] dime_inv, nick_inv;
    logic dime_go, dime_wait, dime_seen, dime_to;
    logic nick_go, nick_wait, nick_seen, nick_to;
    logic wait_any;

    logic [AW-1:0] d_full, d_sel, rem, n_full, n_sel;
    logic          short_nick;

    assign dime_go   = (state_q == S_EJ_DIME);
    assign dime_wait = (state_q == S_WT_DIME);
    assign nick_go   = (state_q == S_EJ_NICK);
    assign nick_wait = (state_q == S_WT_NICK);
    assign wait_any  = dime_wait | nick_wait;

    coin_hopper_if #(.INV_W(INV_W), .TIMEOUT(TIMEOUT)) u_dime (
        .clk(clk), .reset(reset), .eject_en(dime_go), .wait_en(dime_wait),
        .ack(dime_ack), .restock_en(restock_en), .restock_hold(wait_any),
        .restock_val(restock_dimes), .eject(dime_eject), .ack_seen(dime_seen),
        .timed_out(dime_to), .inv(dime_inv)
    );

    coin_hopper_if #(.INV_W(INV_W), .TIMEOUT(TIMEOUT)) u_nick (
        .clk(clk), .reset(reset), .eject_en(nick_go), .wait_en(nick_wait),
        .ack(nickel_ack), .restock_en(restock_en), .restock_hold(wait_any),
        .restock_val(restock_nick), .eject(nickel_eject), .ack_seen(nick_seen),
        .timed_out(nick_to), .inv(nick_inv)
    );

    // Dimes first, limited by stock; the rest in nickels. change%5 is dropped.
    always_comb begin
        d_full     = AW'(change_q) / AW'(DIME_CENTS);
        d_sel      = (AW'(dime_inv) < d_full) ? AW'(dime_inv) : d_full;
        rem        = AW'(change_q) - d_sel * AW'(DIME_CENTS);
        n_full     = rem / AW'(NICKEL_CENTS);
        short_nick = n_full > AW'(nick_inv);
        n_sel      = short_nick ? AW'(nick_inv) : n_full;
    end

    always_comb begin
        state_d      = state_q;
        change_d     = change_q;
        is_vend_d    = is_vend_q;
        dcnt_d       = dcnt_q;
        ncnt_d       = ncnt_q;
        vend_ok      = 1'b0;
        vend_denied  = 1'b0;
        credit_clear = 1'b0;
        done         = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (vend_req && credit >= N'(PRICE)) begin
                    change_d  = credit - N'(PRICE);
                    is_vend_d = 1'b1;
                    state_d   = S_CALC;
                end else begin
                    // A short vend is refused here; a simultaneous refund still runs.
                    vend_denied = vend_req;
                    if (refund_req) begin
                        change_d  = credit;
                        is_vend_d = 1'b0;
                        state_d   = S_CALC;
                    end
                end
            end
            S_CALC: begin
                if (is_vend_q && short_nick) begin
                    vend_denied = 1'b1;
                    state_d     = S_IDLE;
                end else begin
                    vend_ok      = is_vend_q;
                    credit_clear = 1'b1;
                    dcnt_d       = DW'(d_sel);
                    ncnt_d       = NW'(n_sel);
                    if (d_sel != '0)      state_d = S_EJ_DIME;
                    else if (n_sel != '0) state_d = S_EJ_NICK;
                    else                  state_d = S_DONE;
                end
            end
            S_EJ_DIME: state_d = S_WT_DIME;
            S_WT_DIME: begin
                if (dime_seen) begin
                    dcnt_d = dcnt_q - DW'(1);
                    if (dcnt_q > DW'(1))   state_d = S_EJ_DIME;
                    else if (ncnt_q != '0) state_d = S_EJ_NICK;
                    else                   state_d = S_DONE;
                end else if (dime_to) begin
                    state_d = S_JAM;
                end
            end
            S_EJ_NICK: state_d = S_WT_NICK;
            S_WT_NICK: begin
                if (nick_seen) begin
                    ncnt_d = ncnt_q - NW'(1);
                    if (ncnt_q > NW'(1)) state_d = S_EJ_NICK;
                    else                 state_d = S_DONE;
                end else if (nick_to) begin
                    state_d = S_JAM;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            S_JAM:   state_d = S_JAM;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            change_q  <= '0;
            is_vend_q <= 1'b0;
            dcnt_q    <= '0;
            ncnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            change_q  <= change_d;
            is_vend_q <= is_vend_d;
            dcnt_q    <= dcnt_d;
            ncnt_q    <= ncnt_d;
        end
    end

    assign busy       = (state_q != S_IDLE);
    assign jam        = (state_q == S_JAM);
    assign exact_only = (dime_inv == '0) || (nick_inv < INV_W'(2));
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_change_dispense_ctrl.sv
// Directed bench for change_dispense_ctrl: vend with change, nickel-only
// refund, refused vends, vend+refund collision, exact price, stray acks,
// restock blocking, jam timeout and asynchronous reset during payout.
module tb_change_dispense_ctrl;
    import vend_pkg::*;

    localparam int TIMEOUT = 255;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       vend_req = 1'b0, refund_req = 1'b0;
    logic [5:0] credit = '0;
    logic       dime_ack = 1'b0, nickel_ack = 1'b0;
    logic       restock_en = 1'b0;
    logic [7:0] restock_dimes = '0, restock_nick = '0;
    logic       dime_eject, nickel_eject, vend_ok, vend_denied, credit_clear;
    logic       busy, done, jam, exact_only;
    logic [2:0] state_dbg;

    int errors = 0;
    int checks = 0;
    int n_dime_ej, n_nick_ej, n_vend_ok, n_denied, n_clear, n_done;
    bit auto_ack = 1'b1;
    bit pend_d, pend_n;

    change_dispense_ctrl #(.PRICE(30), .N(6), .INV_W(8), .TIMEOUT(TIMEOUT)) u_dut (
        .clk(clk), .reset(reset), .vend_req(vend_req), .refund_req(refund_req),
        .credit(credit), .dime_ack(dime_ack), .nickel_ack(nickel_ack),
        .restock_en(restock_en), .restock_dimes(restock_dimes), .restock_nick(restock_nick),
        .dime_eject(dime_eject), .nickel_eject(nickel_eject), .vend_ok(vend_ok),
        .vend_denied(vend_denied), .credit_clear(credit_clear), .busy(busy), .done(done),
        .jam(jam), .exact_only(exact_only), .state_dbg(state_dbg)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // pulse counters, sampled on the falling edge
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (dime_eject)   n_dime_ej++;
                if (nickel_eject) n_nick_ej++;
                if (vend_ok)      n_vend_ok++;
                if (vend_denied)  n_denied++;
                if (credit_clear) n_clear++;
                if (done)         n_done++;
            end
        end
    end

    // hopper model: acks each eject one cycle later while auto_ack is set
    initial begin
        pend_d = 1'b0;
        pend_n = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (auto_ack && !reset) begin
                dime_ack   = pend_d;
                nickel_ack = pend_n;
                pend_d     = dime_eject;
                pend_n     = nickel_eject;
            end else begin
                pend_d = 1'b0;
                pend_n = 1'b0;
            end
        end
    end

    // driver tasks: all start and end 1 time unit after a rising edge
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_counts();
        n_dime_ej = 0; n_nick_ej = 0; n_vend_ok = 0;
        n_denied = 0;  n_clear = 0;   n_done = 0;
    endtask

    task automatic restock(input logic [7:0] d, input logic [7:0] n);
        restock_dimes = d;
        restock_nick  = n;
        restock_en    = 1'b1;
        step(1);
        restock_en    = 1'b0;
    endtask

    task automatic request(input logic v, input logic r, input logic [5:0] c);
        credit     = c;
        vend_req   = v;
        refund_req = r;
        step(1);
        vend_req   = 1'b0;
        refund_req = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int k;
        k = 0;
        while (n_done == 0 && k < budget) begin
            step(1);
            k++;
        end
        checks++;
        if (n_done == 0) begin
            errors++;
            $display("FAIL %s_done_timeout: got no done, expected done within %0d cycles", name, budget);
        end
    endtask

    // scenarios
    task automatic test_reset();
        reset = 1'b1;
        step(2);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
        checks++; if (jam !== 1'b0) begin errors++; $display("FAIL rst_jam: got %b expected 0", jam); end
        checks++; if ({dime_eject, nickel_eject, vend_ok, vend_denied, credit_clear, done} !== 6'b0) begin
            errors++; $display("FAIL rst_pulses: got %b expected 000000",
                {dime_eject, nickel_eject, vend_ok, vend_denied, credit_clear, done}); end
        checks++; if (exact_only !== 1'b1) begin errors++; $display("FAIL rst_exact_only: got %b expected 1", exact_only); end
        checks++; if (u_dut.dime_inv !== 8'd0 || u_dut.nick_inv !== 8'd0) begin errors++;
            $display("FAIL rst_inv: got %0d/%0d expected 0/0", u_dut.dime_inv, u_dut.nick_inv); end
        reset = 1'b0;
        step(1);
    endtask

    task automatic test_vend_change();
        restock(8'd10, 8'd10);
        checks++; if (exact_only !== 1'b0) begin errors++; $display("FAIL vend_exact_only: got %b expected 0", exact_only); end
        clear_counts();
        request(1'b1, 1'b0, 6'd45);
        step(2);
        request(1'b0, 1'b1, 6'd45);   // arrives while busy: must be ignored
        wait_done(40, "vend45");
        step(3);
        checks++; if (n_vend_ok !== 1) begin errors++; $display("FAIL vend_ok_count: got %0d expected 1", n_vend_ok); end
        checks++; if (n_clear !== 1) begin errors++; $display("FAIL vend_clear_count: got %0d expected 1", n_clear); end
        checks++; if (n_dime_ej !== 1) begin errors++; $display("FAIL vend_dimes: got %0d expected 1", n_dime_ej); end
        checks++; if (n_nick_ej !== 1) begin errors++; $display("FAIL vend_nickels: got %0d expected 1", n_nick_ej); end
        checks++; if (n_done !== 1) begin errors++; $display("FAIL vend_done_count: got %0d expected 1", n_done); end
        checks++; if (u_dut.dime_inv !== 8'd9 || u_dut.nick_inv !== 8'd9) begin errors++;
            $display("FAIL vend_inv: got %0d/%0d expected 9/9", u_dut.dime_inv, u_dut.nick_inv); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL vend_idle: got busy=%b expected 0", busy); end
    endtask

    task automatic test_refund_nickels();
        restock(8'd0, 8'd10);
        checks++; if (exact_only !== 1'b1) begin errors++; $display("FAIL ref_exact_only_pre: got %b expected 1", exact_only); end
        clear_counts();
        request(1'b0, 1'b1, 6'd50);
        wait_done(80, "refund50");
        checks++; if (n_nick_ej !== 10) begin errors++; $display("FAIL ref_nickels: got %0d expected 10", n_nick_ej); end
        checks++; if (n_dime_ej !== 0) begin errors++; $display("FAIL ref_dimes: got %0d expected 0", n_dime_ej); end
        checks++; if (n_clear !== 1 || n_vend_ok !== 0) begin errors++;
            $display("FAIL ref_clear_vend: got clear=%0d vend_ok=%0d expected 1/0", n_clear, n_vend_ok); end
        checks++; if (u_dut.nick_inv !== 8'd0) begin errors++; $display("FAIL ref_nick_inv: got %0d expected 0", u_dut.nick_inv); end
        checks++; if (exact_only !== 1'b1) begin errors++; $display("FAIL ref_exact_only: got %b expected 1", exact_only); end
    endtask

    task automatic test_vend_denied_change();
        restock(8'd10, 8'd0);
        clear_counts();
        credit   = 6'd35;
        vend_req = 1'b1;
        step(1);
        vend_req = 1'b0;
        checks++; if (busy !== 1'b1 || vend_denied !== 1'b1) begin errors++;
            $display("FAIL deny_calc: got busy=%b denied=%b expected 1/1", busy, vend_denied); end
        step(1);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL deny_busy_back: got %b expected 0", busy); end
        checks++; if (n_denied !== 1 || n_clear !== 0 || n_vend_ok !== 0) begin errors++;
            $display("FAIL deny_pulses: got denied=%0d clear=%0d ok=%0d expected 1/0/0", n_denied, n_clear, n_vend_ok); end
        checks++; if (u_dut.dime_inv !== 8'd10) begin errors++; $display("FAIL deny_inv: got %0d expected 10", u_dut.dime_inv); end
    endtask

    task automatic test_vend_refund_same_cycle();
        clear_counts();
        credit     = 6'd20;
        vend_req   = 1'b1;
        refund_req = 1'b1;
        #1;
        checks++; if (vend_denied !== 1'b1) begin errors++; $display("FAIL both_denied_now: got %b expected 1", vend_denied); end
        step(1);
        vend_req   = 1'b0;
        refund_req = 1'b0;
        wait_done(40, "both20");
        checks++; if (n_dime_ej !== 2 || n_nick_ej !== 0) begin errors++;
            $display("FAIL both_coins: got %0d dimes %0d nickels expected 2/0", n_dime_ej, n_nick_ej); end
        checks++; if (n_denied !== 1 || n_clear !== 1 || n_vend_ok !== 0) begin errors++;
            $display("FAIL both_pulses: got denied=%0d clear=%0d ok=%0d expected 1/1/0", n_denied, n_clear, n_vend_ok); end
        checks++; if (u_dut.dime_inv !== 8'd8) begin errors++; $display("FAIL both_inv: got %0d expected 8", u_dut.dime_inv); end
    endtask

    task automatic test_exact_price();
        clear_counts();
        request(1'b1, 1'b0, 6'd30);
        wait_done(10, "exact30");
        checks++; if (n_vend_ok !== 1 || n_dime_ej !== 0 || n_nick_ej !== 0) begin errors++;
            $display("FAIL exact_vend: got ok=%0d dimes=%0d nickels=%0d expected 1/0/0", n_vend_ok, n_dime_ej, n_nick_ej); end
        clear_counts();
        request(1'b1, 1'b0, 6'd29);
        checks++; if (busy !== 1'b0 || n_denied !== 1 || n_clear !== 0) begin errors++;
            $display("FAIL short29: got busy=%b denied=%0d clear=%0d expected 0/1/0", busy, n_denied, n_clear); end
    endtask

    task automatic test_restock_block_and_jam();
        int k;
        auto_ack = 1'b0;
        restock(8'd10, 8'd10);
        dime_ack   = 1'b1;
        nickel_ack = 1'b1;
        step(1);
        dime_ack   = 1'b0;
        nickel_ack = 1'b0;
        checks++; if (u_dut.dime_inv !== 8'd10 || u_dut.nick_inv !== 8'd10) begin errors++;
            $display("FAIL stray_ack_inv: got %0d/%0d expected 10/10", u_dut.dime_inv, u_dut.nick_inv); end
        clear_counts();
        request(1'b0, 1'b1, 6'd40);
        k = 0;
        while (state_dbg !== S_WT_DIME && k < 10) begin step(1); k++; end
        checks++; if (state_dbg !== S_WT_DIME) begin errors++; $display("FAIL jam_reach_wait: got state %0d expected %0d", state_dbg, S_WT_DIME); end
        restock_dimes = 8'd50;
        restock_nick  = 8'd50;
        restock_en    = 1'b1;
        step(1);
        restock_en    = 1'b0;
        checks++; if (u_dut.dime_inv !== 8'd10 || u_dut.nick_inv !== 8'd10) begin errors++;
            $display("FAIL restock_held: got %0d/%0d expected 10/10", u_dut.dime_inv, u_dut.nick_inv); end
        dime_ack   = 1'b1;
        restock_en = 1'b1;
        step(1);
        dime_ack   = 1'b0;
        restock_en = 1'b0;
        checks++; if (u_dut.dime_inv !== 8'd9 || u_dut.nick_inv !== 8'd10) begin errors++;
            $display("FAIL ack_beats_restock: got %0d/%0d expected 9/10", u_dut.dime_inv, u_dut.nick_inv); end
        k = 0;
        while (jam !== 1'b1 && k < TIMEOUT + 20) begin step(1); k++; end
        checks++; if (jam !== 1'b1 || busy !== 1'b1) begin errors++;
            $display("FAIL jam_set: got jam=%b busy=%b expected 1/1", jam, busy); end
        checks++; if (k < TIMEOUT - 2) begin errors++; $display("FAIL jam_too_early: got %0d cycles expected about %0d", k, TIMEOUT); end
        request(1'b0, 1'b1, 6'd40);
        step(5);
        checks++; if (jam !== 1'b1 || n_dime_ej !== 2 || n_clear !== 1) begin errors++;
            $display("FAIL jam_hold: got jam=%b dimes=%0d clear=%0d expected 1/2/1", jam, n_dime_ej, n_clear); end
        reset = 1'b1;
        #1;
        checks++; if (jam !== 1'b0 || busy !== 1'b0) begin errors++;
            $display("FAIL jam_reset: got jam=%b busy=%b expected 0/0", jam, busy); end
        step(1);
        reset = 1'b0;
        step(1);
        auto_ack = 1'b1;
    endtask

    task automatic test_reset_mid_wait_nick();
        int k;
        restock(8'd0, 8'd10);
        clear_counts();
        request(1'b0, 1'b1, 6'd30);
        k = 0;
        while (state_dbg !== S_WT_NICK && k < 20) begin step(1); k++; end
        checks++; if (state_dbg !== S_WT_NICK) begin errors++; $display("FAIL mid_reach_wait: got state %0d expected %0d", state_dbg, S_WT_NICK); end
        #2;
        reset = 1'b1;
        #1;
        checks++; if ({busy, jam, done, dime_eject, nickel_eject, vend_ok, vend_denied, credit_clear} !== 8'b0) begin
            errors++; $display("FAIL mid_async_outputs: got %b expected 00000000",
                {busy, jam, done, dime_eject, nickel_eject, vend_ok, vend_denied, credit_clear}); end
        checks++; if (u_dut.dime_inv !== 8'd0 || u_dut.nick_inv !== 8'd0 || state_dbg !== S_IDLE) begin errors++;
            $display("FAIL mid_async_state: got inv %0d/%0d state %0d expected 0/0/0", u_dut.dime_inv, u_dut.nick_inv, state_dbg); end
        step(1);
        reset = 1'b0;
        step(2);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_after_release: got busy=%b expected 0", busy); end
    endtask

    // sequence and report
    initial begin
        clear_counts();
        test_reset();
        test_vend_change();
        test_refund_nickels();
        test_vend_denied_change();
        test_vend_refund_same_cycle();
        test_exact_price();
        test_restock_block_and_jam();
        test_reset_mid_wait_nick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
